hamnhan_mult_core: RTL and testbench

Sequential shift-add multiplier datapath that sits directly downstream of the multiplier AXI4-Lite slave register file. The slave writes operands and a start bit into this core, polls busy/result_valid, and reads back the 2*WIDTH-bit product. Signed and unsigned modes are supported. One product is in flight at a time, with a start/done handshake.

---
 rtl/hamnhan_pkg.sv | 31 +++
 rtl/hamnhan_mult_if.sv | 28 ++
 rtl/hamnhan_mult_core.sv | 103 ++++++++++
 tb/tb_hamnhan_mult_core.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/hamnhan_pkg.sv
// hamnhan_pkg: shared types and constants for the shift-add multiplier core.
//   state_t   : core FSM encoding (IDLE/RUN/DONE, 2 bits)
//   DEF_WIDTH : default operand width
//   REG_*     : AXI4-Lite slave register offsets and bit positions that
//               the register file uses to drive/observe the core.
package hamnhan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;

  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_OPA    = 8'h04;
  localparam logic [7:0] REG_OPB    = 8'h08;
  localparam logic [7:0] REG_RES_LO = 8'h0C;
  localparam logic [7:0] REG_RES_HI = 8'h10;
  localparam logic [7:0] REG_STATUS = 8'h14;

  // CTRL bits
  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_SIGNED_BIT = 1;
  localparam int CTRL_CLEAR_BIT  = 2;
  // STATUS bits
  localparam int STAT_BUSY_BIT   = 0;
  localparam int STAT_VALID_BIT  = 1;

endpackage

// File: rtl/hamnhan_mult_if.sv
// hamnhan_mult_if: start/done handshake between the register file (master)
// and the multiplier core (slave).
//   master drives : start, op_a, op_b, signed_mode, clear
//   slave drives  : busy, done, result_valid, result_lo, result_hi
interface hamnhan_mult_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             signed_mode;
  logic             clear;
  logic             busy;
  logic             done;
  logic             result_valid;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;

  modport master (
    output start, op_a, op_b, signed_mode, clear,
    input  busy, done, result_valid, result_lo, result_hi
  );

  modport slave (
    input  start, op_a, op_b, signed_mode, clear,
    output busy, done, result_valid, result_lo, result_hi
  );
endinterface

// File: rtl/hamnhan_mult_core.sv
// hamnhan_mult_core: sequential shift-add multiplier, one product in flight.
//   S_AXI_ACLK    : clock, rising edge
//   S_AXI_ARESETN : synchronous active-low reset
//   bus (slave)   : start/op_a/op_b/signed_mode/clear in,
//                   busy/done/result_valid/result_lo/result_hi out
// Signed products are formed on magnitudes and negated at the end, so the
// datapath itself is purely unsigned. Start-to-done is WIDTH+1 cycles: WIDTH
// shift-add steps plus one cycle for the final sign fix-up.
module hamnhan_mult_core
  import hamnhan_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic S_AXI_ACLK,
  input  logic S_AXI_ARESETN,
  hamnhan_mult_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic               neg;
  logic               busy_q;
  logic               done_q;
  logic               valid_q;
  logic [2*WIDTH-1:0] res_q;

  logic               sgn_act;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     sum;
  logic               accept;

  assign sgn_act = SIGNED_EN && bus.signed_mode;
  // Most negative value negates to itself, which reads correctly as an
  // unsigned magnitude of 2^(WIDTH-1).
  assign mag_a   = (sgn_act && bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
  assign mag_b   = (sgn_act && bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;
  assign sum     = {1'b0, acc[2*WIDTH-1:WIDTH]}
                 + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};
  assign accept  = bus.start && (state == IDLE || state == DONE);

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      res_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            mcand   <= mag_a;
            mplier  <= mag_b;
            neg     <= sgn_act && (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
            acc     <= '0;
            cnt     <= CNT_W'(WIDTH);
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
            state   <= RUN;
          end else begin
            if (bus.clear) valid_q <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          if (cnt != '0) begin
            // {carry, acc} >> 1 with the partial product added to the top half
            acc    <= {sum, acc[WIDTH-1:1]};
            mplier <= mplier >> 1;
            cnt    <= cnt - CNT_W'(1);
          end else begin
            res_q   <= neg ? -acc : acc;
            done_q  <= 1'b1;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.result_valid = valid_q;
  assign bus.result_lo    = res_q[WIDTH-1:0];
  assign bus.result_hi    = res_q[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_hamnhan_mult_core.sv
// tb_hamnhan_mult_core: directed-vector bench for hamnhan_mult_core (WIDTH=32).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_hamnhan_mult_core;
  import hamnhan_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  hamnhan_mult_if #(.WIDTH(32)) bus ();

  hamnhan_mult_core #(.WIDTH(32), .SIGNED_EN(1'b1)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  // Present a start for exactly one rising edge; returns at the falling edge
  // right after the accepting edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    bus.op_a = a; bus.op_b = b; bus.signed_mode = s; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Counts falling edges until done is seen; -1 if it never comes.
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin cyc = i; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({bus.busy, bus.done, bus.result_valid} !== 3'b000 ||
        {bus.result_hi, bus.result_lo} !== 64'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%b done=%b rv=%b res=%h, want 0/0/0/0",
               bus.busy, bus.done, bus.result_valid, {bus.result_hi, bus.result_lo});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    int cyc;
    start_op(32'd7, 32'd6, 1'b0);
    n_vec++;
    if (bus.busy !== 1'b1) begin
      n_err++; $display("FAIL unsigned_busy: got %b want 1", bus.busy);
    end
    wait_done(cyc);
    n_vec++;
    if (cyc != 33) begin
      n_err++; $display("FAIL unsigned_latency: got %0d cycles want 33", cyc);
    end
    n_vec++;
    if (bus.result_hi !== 32'h0 || bus.result_lo !== 32'h2A || bus.result_valid !== 1'b1 ||
        bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL unsigned_7x6: got hi=%h lo=%h rv=%b busy=%b want 00000000/0000002a/1/0",
               bus.result_hi, bus.result_lo, bus.result_valid, bus.busy);
    end
    @(negedge clk);
    n_vec++;
    if (bus.done !== 1'b0 || bus.result_valid !== 1'b1) begin
      n_err++; $display("FAIL done_pulse: got done=%b rv=%b want 0/1", bus.done, bus.result_valid);
    end
  endtask

  task automatic test_products();
    logic [31:0] va [4] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFD};
    logic [31:0] vb [4] = '{32'hFFFFFFFF, 32'd5,        32'h80000000, 32'd5};
    logic        vs [4] = '{1'b0,         1'b1,         1'b1,         1'b0};
    logic [63:0] ve [4] = '{64'hFFFFFFFE_00000001, 64'hFFFFFFFF_FFFFFFF1,
                            64'h40000000_00000000, 64'h00000004_FFFFFFF1};
    int cyc;
    for (int i = 0; i < 4; i++) begin
      start_op(va[i], vb[i], vs[i]);
      wait_done(cyc);
      n_vec++;
      if (cyc != 33 || {bus.result_hi, bus.result_lo} !== ve[i]) begin
        n_err++;
        $display("FAIL product_%0d: got %h after %0d cycles want %h after 33",
                 i, {bus.result_hi, bus.result_lo}, cyc, ve[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int ndone;
    start_op(32'd4, 32'd5, 1'b0);
    cyc = -1;
    for (int i = 1; i <= 60; i++) begin
      if (i == 10) begin bus.op_a = 32'd9; bus.op_b = 32'd9; bus.start = 1'b1; end
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done === 1'b1) begin cyc = i; break; end
    end
    n_vec++;
    if (cyc != 33 || bus.result_lo !== 32'd20 || bus.result_hi !== 32'd0) begin
      n_err++;
      $display("FAIL start_in_run: got lo=%0d hi=%0d after %0d cycles want 20/0 after 33",
               bus.result_lo, bus.result_hi, cyc);
    end
    // now in the DONE cycle: a start here must be accepted
    start_op(32'd9, 32'd9, 1'b0);
    n_vec++;
    if (bus.busy !== 1'b1 || bus.result_valid !== 1'b0) begin
      n_err++;
      $display("FAIL start_in_done: got busy=%b rv=%b want 1/0", bus.busy, bus.result_valid);
    end
    ndone = 0;
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin ndone++; if (cyc < 0) cyc = i; end
    end
    n_vec++;
    if (cyc != 33 || ndone != 1 || bus.result_lo !== 32'd81) begin
      n_err++;
      $display("FAIL back_to_back_9x9: got lo=%0d done_at=%0d pulses=%0d want 81/33/1",
               bus.result_lo, cyc, ndone);
    end
  endtask

  task automatic test_reset_mid_op();
    int ndone = 0;
    start_op(32'd100, 32'd100, 1'b0);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_vec++;
    if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0 ||
        {bus.result_hi, bus.result_lo} !== 64'h0 || dut.state !== IDLE) begin
      n_err++;
      $display("FAIL reset_mid_op: got busy=%b rv=%b res=%h state=%0d want 0/0/0/IDLE",
               bus.busy, bus.result_valid, {bus.result_hi, bus.result_lo}, dut.state);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
    n_vec++;
    if (ndone != 0) begin
      n_err++; $display("FAIL reset_no_done: got %0d done pulses want 0", ndone);
    end
  endtask

  task automatic test_clear();
    int cyc;
    start_op(32'd7, 32'd6, 1'b0);
    wait_done(cyc);
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    n_vec++;
    if (bus.result_valid !== 1'b0 || bus.result_lo !== 32'h2A) begin
      n_err++;
      $display("FAIL clear_idle: got rv=%b lo=%h want 0/0000002a", bus.result_valid, bus.result_lo);
    end
    // clear mid-run and clear on the edge where done rises: both ignored
    start_op(32'd7, 32'd6, 1'b0);
    cyc = -1;
    for (int i = 1; i <= 60; i++) begin
      bus.clear = (i == 5 || i == 33);
      @(negedge clk);
      bus.clear = 1'b0;
      if (bus.done === 1'b1) begin cyc = i; break; end
    end
    n_vec++;
    if (cyc != 33 || bus.result_valid !== 1'b1 || bus.result_lo !== 32'h2A) begin
      n_err++;
      $display("FAIL clear_in_run: got rv=%b lo=%h done_at=%0d want 1/0000002a/33",
               bus.result_valid, bus.result_lo, cyc);
    end
    // clear together with an accepted start: start wins, valid drops
    bus.clear = 1'b1;
    start_op(32'd3, 32'd3, 1'b0);
    bus.clear = 1'b0;
    n_vec++;
    if (bus.busy !== 1'b1 || bus.result_valid !== 1'b0 || bus.result_lo !== 32'h2A) begin
      n_err++;
      $display("FAIL clear_with_start: got busy=%b rv=%b lo=%h want 1/0/0000002a",
               bus.busy, bus.result_valid, bus.result_lo);
    end
    wait_done(cyc);
    n_vec++;
    if (cyc != 33 || bus.result_lo !== 32'd9) begin
      n_err++; $display("FAIL clear_start_result: got lo=%0d at %0d want 9 at 33", bus.result_lo, cyc);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.clear = 1'b0; bus.signed_mode = 1'b0;
    bus.op_a = '0; bus.op_b = '0;
    @(negedge clk);
    test_reset();
    test_unsigned();
    test_products();
    test_back_to_back();
    test_reset_mid_op();
    test_clear();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
